multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Multi-cycle successor to the single-cycle opcode decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and emits the datapath control strobes per state (mem_reg, reg_write, branch, mem_read, mem_write, mem_enable, ALU_op, ALU_src, reg_dst). Waits on a memory-ready handshake and flags illegal opcodes. Sits between the instruction register and the datapath/memory interface.

Parameters:
OPCODE_W, 4, opcode width; must be >= 4. Bits above [3:0] must be zero, otherwise the opcode is illegal.
ALU_OP_W, 4, ALU_op width; must be >= 4. Values are zero-extended.
MEM_TIMEOUT, 15, cycles without mem_ready before bus error. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  opcode field from the instruction register; sampled in DECODE.
- zero  in  1  ALU zero flag; sampled in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  update the PC.
- pc_src  out  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target.
- mem_enable, mem_read, mem_write  out  1 each  memory strobes.
- mem_reg  out  1  write-back source: 1 = memory, 0 = ALU.
- reg_write  out  1  register-file write.
- reg_dst  out  1  destination: 1 = rd, 0 = rt.
- ALU_src  out  1  ALU B operand: 1 = immediate, 0 = register.
- branch  out  1  branch-compare cycle.
- ALU_op  out  ALU_OP_W  ALU operation.
- illegal_op  out  1  one-cycle pulse.
- halted  out  1  core halted.
- bus_err  out  1  sticky; tied to 0 unless MEM_TIMEOUT_EN.

Behaviour:
- Opcode map:
  - 0x0-0x7: reg-reg ALU op, ALU_op = opcode.
  - 0x8 ADDI, 0x9 LW, 0xA SW: ALU_op = 0 (ADD).
  - 0xB BEQ: ALU_op = 1 (SUB).
  - 0xC JMP.
  - 0xF HALT.
  - 0xD, 0xE, or any nonzero upper bit: illegal.
- Outputs are a combinational function of state and the opcode latched in DECODE. Outputs not named below are 0.
- Reset (async): state = IDLE, latched opcode = 0. All outputs 0, including halted and bus_err.
- IDLE: all outputs 0; moves to FETCH on the next clk.
- FETCH: mem_enable = 1, mem_read = 1. Holds until mem_ready. On the mem_ready cycle: ir_write = 1, pc_write = 1, pc_src = 0; next state DECODE.
- DECODE: latches opcode; one cycle; next state EXEC.
- EXEC, by class:
  - ALU: ALU_src = 0, ALU_op as mapped → WB.
  - ADDI: ALU_src = 1 → WB.
  - LW / SW: ALU_src = 1, ALU_op = 0 → MEM.
  - BEQ: branch = 1, ALU_op = 1, pc_src = 1, pc_write = zero → FETCH.
  - JMP: pc_write = 1, pc_src = 2 → FETCH.
  - HALT: → HALT.
  - Illegal: illegal_op = 1 for one cycle, no other strobes → FETCH (treated as NOP).
- MEM: mem_enable = 1, mem_read = LW, mem_write = SW, ALU_src = 1. Strobes are held until mem_ready. On mem_ready, LW → WB and SW → FETCH.
- WB: reg_write = 1 for one cycle; mem_reg = LW; reg_dst = 1 for ALU class only. Next state FETCH.
- HALT: halted = 1, all strobes 0. Absorbing until reset.
- Latency per instruction, with mem_ready immediate: ALU/ADDI 4 cycles, LW 5, SW 4, BEQ/JMP 3.
- mem_ready outside FETCH/MEM is ignored.
- Reset mid-access drops all strobes immediately; no partial write-back.
- An opcode change after DECODE has no effect until the next DECODE.

Optional Feature:
MEM_TIMEOUT_EN:
- When defined: a counter of width clog2(MEM_TIMEOUT+1) counts consecutive FETCH/MEM cycles without mem_ready. It clears on mem_ready and on state entry. When it reaches MEM_TIMEOUT, bus_err is set (sticky), strobes drop, and state → HALT.
- When undefined: no counter; waits on mem_ready indefinitely; bus_err = 0.

Decomposition:
- Package control_pkg holds:
  - state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - opcode localparams.
  - instruction class enum: ALU, ADDI, LW, SW, BEQ, JMP, HALT, ILLEGAL.
  - pc_src encodings.
  - ALU_op constants: ADD = 0, SUB = 1.
- Sub-module control_decode: combinational opcode → {class, ALU_op}, OPCODE_W-aware. The FSM instantiates it once.

Test Plan:
- Reset mid-FETCH, then release → outputs all 0 during reset; IDLE for 1 cycle, then FETCH with mem_read = 1, mem_enable = 1.
- Opcode 0x2, mem_ready held 1 → WB cycle has reg_write = 1, reg_dst = 1, mem_reg = 0, ALU_op = 2; next FETCH 4 cycles after the first.
- LW (0x9), mem_ready low 3 cycles in MEM → mem_read held 4 cycles; then WB with reg_write = 1, mem_reg = 1, reg_dst = 0.
- BEQ (0xB), zero = 1, then again with zero = 0 → zero = 1: pc_write = 1, pc_src = 1, branch = 1. zero = 0: branch = 1, pc_write = 0.
- Opcode 0xE, then 0xF → 0xE: single-cycle illegal_op pulse, then FETCH. 0xF: halted = 1 with all strobes 0 until rst_n.
- With MEM_TIMEOUT_EN, MEM_TIMEOUT = 15, mem_ready never asserted → bus_err = 1 and HALT 15 cycles after FETCH entry. Without the macro, still in FETCH after 100 cycles and bus_err = 0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle control FSM and its opcode decoder.
package control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_ADDI,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_JMP,
        CL_HALT,
        CL_ILLEGAL
    } iclass_t;

    localparam logic [3:0] OP_ALU_MAX = 4'h7;
    localparam logic [3:0] OP_ADDI    = 4'h8;
    localparam logic [3:0] OP_LW      = 4'h9;
    localparam logic [3:0] OP_SW      = 4'hA;
    localparam logic [3:0] OP_BEQ     = 4'hB;
    localparam logic [3:0] OP_JMP     = 4'hC;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    function automatic logic is_mem_wait(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: classifies an opcode and produces its zero-extended ALU operation.
module control_decode
    import control_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 4
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output logic [2:0]          o_class,
    output logic [ALU_OP_W-1:0] o_alu_op
);

    logic       w_upper_nz;
    logic [3:0] w_low;

    // Any bit above the 4-bit opcode space makes the instruction illegal.
    assign w_upper_nz = |(i_opcode >> 4);
    assign w_low      = i_opcode[3:0];

    always_comb begin
        o_class  = CL_ILLEGAL;
        o_alu_op = '0;
        if (!w_upper_nz) begin
            if (w_low <= OP_ALU_MAX) begin
                o_class  = CL_ALU;
                o_alu_op = ALU_OP_W'(w_low);
            end else begin
                case (w_low)
                    OP_ADDI: begin
                        o_class  = CL_ADDI;
                        o_alu_op = ALU_OP_W'(ALU_ADD);
                    end
                    OP_LW: begin
                        o_class  = CL_LW;
                        o_alu_op = ALU_OP_W'(ALU_ADD);
                    end
                    OP_SW: begin
                        o_class  = CL_SW;
                        o_alu_op = ALU_OP_W'(ALU_ADD);
                    end
                    OP_BEQ: begin
                        o_class  = CL_BEQ;
                        o_alu_op = ALU_OP_W'(ALU_SUB);
                    end
                    OP_JMP:  o_class = CL_JMP;
                    OP_HALT: o_class = CL_HALT;
                    default: o_class = CL_ILLEGAL;
                endcase
            end
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-ready handshake.
// Optional memory-wait timeout with sticky bus error when MEM_TIMEOUT_EN is defined.
module multicycle_control_fsm
    import control_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                mem_enable,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_reg,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                ALU_src,
    output logic                branch,
    output logic [ALU_OP_W-1:0] ALU_op,
    output logic                illegal_op,
    output logic                halted,
    output logic                bus_err
);

    state_t                r_state;
    state_t                w_next;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [2:0]            w_class_raw;
    iclass_t               w_class;
    logic [ALU_OP_W-1:0]   w_alu_op;
    logic                  w_timeout;

    // Decode works on the latched opcode so IR changes after DECODE are invisible.
    control_decode #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .i_opcode (r_opcode),
        .o_class  (w_class_raw),
        .o_alu_op (w_alu_op)
    );

    assign w_class = iclass_t'(w_class_raw);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_bus_err;

    // Fires on the last tolerated idle cycle so HALT is entered as the count reaches MEM_TIMEOUT.
    assign w_timeout = is_mem_wait(r_state) && !mem_ready
                       && (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            if ((w_next != r_state) || mem_ready) begin
                r_wait_cnt <= '0;
            end else if (is_mem_wait(r_state)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_opcode <= opcode;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        mem_enable = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_reg    = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        ALU_src    = 1'b0;
        branch     = 1'b0;
        ALU_op     = '0;
        illegal_op = 1'b0;
        halted     = 1'b0;

        case (r_state)
            ST_IDLE: w_next = ST_FETCH;

            ST_FETCH: begin
                mem_enable = 1'b1;
                mem_read   = 1'b1;
                if (w_timeout) begin
                    w_next = ST_HALT;
                end else if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_SEQ;
                    w_next   = ST_DECODE;
                end
            end

            ST_DECODE: w_next = ST_EXEC;

            ST_EXEC: begin
                ALU_op = w_alu_op;
                case (w_class)
                    CL_ALU:  w_next = ST_WB;
                    CL_ADDI: begin
                        ALU_src = 1'b1;
                        w_next  = ST_WB;
                    end
                    CL_LW, CL_SW: begin
                        ALU_src = 1'b1;
                        w_next  = ST_MEM;
                    end
                    CL_BEQ: begin
                        branch   = 1'b1;
                        pc_src   = PC_SRC_BRANCH;
                        pc_write = zero;
                        w_next   = ST_FETCH;
                    end
                    CL_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                        w_next   = ST_FETCH;
                    end
                    CL_HALT: w_next = ST_HALT;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = ST_FETCH;
                    end
                endcase
            end

            ST_MEM: begin
                mem_enable = 1'b1;
                mem_read   = (w_class == CL_LW);
                mem_write  = (w_class == CL_SW);
                ALU_src    = 1'b1;
                ALU_op     = w_alu_op;
                if (w_timeout) begin
                    w_next = ST_HALT;
                end else if (mem_ready) begin
                    w_next = (w_class == CL_LW) ? ST_WB : ST_FETCH;
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                mem_reg   = (w_class == CL_LW);
                reg_dst   = (w_class == CL_ALU);
                ALU_op    = w_alu_op;
                w_next    = ST_FETCH;
            end

            ST_HALT: halted = 1'b1;

            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; covers the MEM_TIMEOUT_EN build when that macro is defined.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       ir_write, pc_write, mem_enable, mem_read, mem_write;
    logic       mem_reg, reg_write, reg_dst, ALU_src, branch;
    logic       illegal_op, halted, bus_err;
    logic [1:0] pc_src;
    logic [3:0] ALU_op;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] PCS_BR  = 32'h0000_0010;
    localparam logic [31:0] PCS_JMP = 32'h0000_0020;
    localparam logic [31:0] IRW     = 32'h0000_0040;
    localparam logic [31:0] PCW     = 32'h0000_0080;
    localparam logic [31:0] MEN     = 32'h0000_0100;
    localparam logic [31:0] MRD     = 32'h0000_0200;
    localparam logic [31:0] MWR     = 32'h0000_0400;
    localparam logic [31:0] MREG    = 32'h0000_0800;
    localparam logic [31:0] RGW     = 32'h0000_1000;
    localparam logic [31:0] RDST    = 32'h0000_2000;
    localparam logic [31:0] ASRC    = 32'h0000_4000;
    localparam logic [31:0] BR      = 32'h0000_8000;
    localparam logic [31:0] ILL     = 32'h0001_0000;
    localparam logic [31:0] HLT     = 32'h0002_0000;
    localparam logic [31:0] BERR    = 32'h0004_0000;
    localparam logic [31:0] HS      = MEN | MRD | IRW | PCW;

    logic [31:0] w_obs;
    assign w_obs = {13'b0, bus_err, halted, illegal_op, branch, ALU_src, reg_dst,
                    reg_write, mem_reg, mem_write, mem_read, mem_enable, pc_write,
                    ir_write, pc_src, ALU_op};

    multicycle_control_fsm #(
        .OPCODE_W    (4),
        .ALU_OP_W    (4),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .mem_enable (mem_enable),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_reg    (mem_reg),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .ALU_src    (ALU_src),
        .branch     (branch),
        .ALU_op     (ALU_op),
        .illegal_op (illegal_op),
        .halted     (halted),
        .bus_err    (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic rdy, input logic z,
                       input logic [3:0] op, input logic [31:0] exp);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        opcode    = op;
        #1;
        chk(tag, w_obs, exp);
    endtask

    task automatic rst_cyc(input string tag, input logic rst_val, input logic [31:0] exp);
        @(negedge clk);
        rst_n     = rst_val;
        mem_ready = 1'b0;
        #1;
        chk(tag, w_obs, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 4'h0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        rst_cyc("reset",       1'b0, 32'h0);
        rst_cyc("reset_hold",  1'b0, 32'h0);
        rst_cyc("idle",        1'b1, 32'h0);
        cyc("fetch_entry",   1'b0, 1'b0, 4'h0, MEN | MRD);
        cyc("fetch_wait",    1'b0, 1'b0, 4'h0, MEN | MRD);
        rst_cyc("rst_mid_fetch", 1'b0, 32'h0);
        rst_cyc("idle2",       1'b1, 32'h0);
        cyc("fetch2",        1'b0, 1'b0, 4'h0, MEN | MRD);

        cyc("alu_fetch",     1'b1, 1'b0, 4'h2, HS);
        cyc("alu_decode",    1'b1, 1'b0, 4'h2, 32'h0);
        cyc("alu_exec",      1'b0, 1'b0, 4'hF, 32'h2);
        cyc("alu_wb",        1'b1, 1'b0, 4'hF, RGW | RDST | 32'h2);

        cyc("lw_fetch",      1'b1, 1'b0, 4'h9, HS);
        cyc("lw_decode",     1'b0, 1'b0, 4'h9, 32'h0);
        cyc("lw_exec",       1'b0, 1'b0, 4'h9, ASRC);
        cyc("lw_mem0",       1'b0, 1'b0, 4'h9, MEN | MRD | ASRC);
        cyc("lw_mem1",       1'b0, 1'b0, 4'h9, MEN | MRD | ASRC);
        cyc("lw_mem2",       1'b0, 1'b0, 4'h9, MEN | MRD | ASRC);
        cyc("lw_mem3",       1'b1, 1'b0, 4'h9, MEN | MRD | ASRC);
        cyc("lw_wb",         1'b0, 1'b0, 4'h9, RGW | MREG);

        cyc("sw_fetch",      1'b1, 1'b0, 4'hA, HS);
        cyc("sw_decode",     1'b0, 1'b0, 4'hA, 32'h0);
        cyc("sw_exec",       1'b0, 1'b0, 4'hA, ASRC);
        cyc("sw_mem",        1'b1, 1'b0, 4'hA, MEN | MWR | ASRC);

        cyc("beq1_fetch",    1'b1, 1'b0, 4'hB, HS);
        cyc("beq1_decode",   1'b0, 1'b0, 4'hB, 32'h0);
        cyc("beq1_exec",     1'b0, 1'b1, 4'hB, BR | PCW | PCS_BR | 32'h1);
        cyc("beq0_fetch",    1'b1, 1'b0, 4'hB, HS);
        cyc("beq0_decode",   1'b0, 1'b1, 4'hB, 32'h0);
        cyc("beq0_exec",     1'b0, 1'b0, 4'hB, BR | PCS_BR | 32'h1);

        cyc("jmp_fetch",     1'b1, 1'b0, 4'hC, HS);
        cyc("jmp_decode",    1'b0, 1'b0, 4'hC, 32'h0);
        cyc("jmp_exec",      1'b0, 1'b0, 4'hC, PCW | PCS_JMP);

        cyc("addi_fetch",    1'b1, 1'b0, 4'h8, HS);
        cyc("addi_decode",   1'b0, 1'b0, 4'h8, 32'h0);
        cyc("addi_exec",     1'b0, 1'b0, 4'h8, ASRC);
        cyc("addi_wb",       1'b0, 1'b0, 4'h8, RGW);

        cyc("ill_fetch",     1'b1, 1'b0, 4'hE, HS);
        cyc("ill_decode",    1'b0, 1'b0, 4'hE, 32'h0);
        cyc("ill_exec",      1'b0, 1'b0, 4'hE, ILL);
        cyc("ill_after",     1'b0, 1'b0, 4'hE, MEN | MRD);

        cyc("halt_fetch",    1'b1, 1'b0, 4'hF, HS);
        cyc("halt_decode",   1'b0, 1'b0, 4'hF, 32'h0);
        cyc("halt_exec",     1'b1, 1'b0, 4'h2, 32'h0);
        cyc("halt0",         1'b1, 1'b0, 4'h2, HLT);
        cyc("halt1",         1'b1, 1'b1, 4'h9, HLT);
        cyc("halt2",         1'b0, 1'b0, 4'h0, HLT);
        rst_cyc("halt_reset", 1'b0, 32'h0);
        rst_cyc("idle3",      1'b1, 32'h0);
        cyc("to_fetch",      1'b0, 1'b0, 4'h0, MEN | MRD);

`ifdef MEM_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            cyc("to_wait", 1'b0, 1'b0, 4'h0, MEN | MRD);
        end
        cyc("to_buserr",     1'b0, 1'b0, 4'h0, HLT | BERR);
        cyc("to_sticky",     1'b1, 1'b0, 4'h0, HLT | BERR);
        rst_cyc("to_reset",  1'b0, 32'h0);
`else
        repeat (99) @(negedge clk);
        cyc("no_timeout",    1'b0, 1'b0, 4'h0, MEN | MRD);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
